// File: rtl/sin_fix_multi.sv
// sin_fix_multi: N-channel sine with a shared core and a post-core
// match/replace correction stage feeding per-channel hold registers.
// Optional feature macro: SIN_FIX_SAT_EN clamps passthrough results with |x|>1.0.
// Sin_theta here is a behavioural stand-in for the vendor sine core: exact
// results at a few reference angles, small-angle passthrough elsewhere.

module Sin_theta #(
  parameter int LAT = 8
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [31:0] pipe_q [LAT];
  logic [31:0] pipe_d [LAT];

  function automatic logic [31:0] sin_ref(input logic [31:0] x);
    case (x)
      32'h3f060a92: sin_ref = 32'h3f000000;
      32'hbf060a92: sin_ref = 32'hbf000000;
      32'h3f490fdb: sin_ref = 32'h3f3504f3;
      32'h3fc90fdb: sin_ref = 32'h3f800000;
      32'hbfc90fdb: sin_ref = 32'hbf800000;
      32'h40800000: sin_ref = 32'hbf41bdce;
      default:      sin_ref = x;
    endcase
  endfunction

  // advance the result pipeline only while the clock enable is high
  always_comb begin
    pipe_d = pipe_q;
    if (clk_en) begin
      pipe_d[0] = sin_ref(data);
      for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  // pipeline registers, cleared by the core's asynchronous clear
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign result = pipe_q[LAT-1];

endmodule

module sin_fix_multi #(
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int CORE_LAT = 8,
  parameter int TBL_D    = 4,
  parameter int TBL_AW   = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               th_valid,
  input  logic [CH_W-1:0]    th_ch,
  input  logic [31:0]        theta,
  output logic               th_ready,
  input  logic               tbl_we,
  input  logic [TBL_AW-1:0]  tbl_addr,
  input  logic               tbl_vld,
  input  logic [31:0]        tbl_match,
  input  logic [31:0]        tbl_repl,
  output logic               sin_valid,
  output logic [CH_W-1:0]    sin_ch,
  output logic [31:0]        sin_res,
  output logic [NCH*32-1:0]  sin_hold,
  output logic [CNT_W-1:0]   fix_cnt
);

  logic [31:0]         core_res;
  logic [CORE_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [CH_W-1:0]     ch_pipe_q [CORE_LAT];
  logic [CH_W-1:0]     ch_pipe_d [CORE_LAT];
  logic [TBL_D-1:0]    tbl_vld_q, tbl_vld_d;
  logic [31:0]         tbl_match_q [TBL_D];
  logic [31:0]         tbl_match_d [TBL_D];
  logic [31:0]         tbl_repl_q [TBL_D];
  logic [31:0]         tbl_repl_d [TBL_D];
  logic                fix_hit;
  logic [31:0]         fix_val;
  logic                out_vld;
  logic [CH_W-1:0]     out_ch;
  logic                sin_valid_q, sin_valid_d;
  logic [CH_W-1:0]     sin_ch_q, sin_ch_d;
  logic [31:0]         sin_res_q, sin_res_d;
  logic [NCH*32-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    fix_cnt_q, fix_cnt_d;

  assign th_ready = en;

  Sin_theta #(.LAT(CORE_LAT)) u_core (
    .clock  (clk),
    .aclr   (~rst),
    .clk_en (en),
    .data   (theta),
    .result (core_res)
  );

  // tag/valid shadow of the core pipeline, moving in lockstep with it
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    ch_pipe_d  = ch_pipe_q;
    if (en) begin
      vld_pipe_d[0] = th_valid;
      ch_pipe_d[0]  = th_ch;
      for (int i = 1; i < CORE_LAT; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        ch_pipe_d[i]  = ch_pipe_q[i-1];
      end
    end
  end

  // table writes land next clock; indices outside the table never decode
  always_comb begin
    tbl_vld_d   = tbl_vld_q;
    tbl_match_d = tbl_match_q;
    tbl_repl_d  = tbl_repl_q;
    if (tbl_we) begin
      for (int i = 0; i < TBL_D; i++) begin
        if (tbl_addr == TBL_AW'(i)) begin
          tbl_vld_d[i]   = tbl_vld;
          tbl_match_d[i] = tbl_match;
          tbl_repl_d[i]  = tbl_repl;
        end
      end
    end
  end

  // lowest matching enabled entry wins; optional clamp of out-of-range passthrough
  always_comb begin
    fix_hit = 1'b0;
    fix_val = core_res;
    for (int i = TBL_D - 1; i >= 0; i--) begin
      if (tbl_vld_q[i] && (tbl_match_q[i] == core_res)) begin
        fix_hit = 1'b1;
        fix_val = tbl_repl_q[i];
      end
    end
`ifdef SIN_FIX_SAT_EN
    if (!fix_hit && !((core_res[30:23] == 8'hff) && (core_res[22:0] != '0)) &&
        ((core_res[30:23] > 8'd127) || ((core_res[30:23] == 8'd127) && (core_res[22:0] != '0)))) begin
      fix_hit = 1'b1;
      fix_val = {core_res[31], 31'h3f800000};
    end
`endif
  end

  // result register, per-channel hold lanes and saturating correction count
  always_comb begin
    out_vld     = vld_pipe_q[CORE_LAT-1];
    out_ch      = ch_pipe_q[CORE_LAT-1];
    sin_valid_d = en & out_vld;
    sin_ch_d    = sin_ch_q;
    sin_res_d   = sin_res_q;
    hold_d      = hold_q;
    fix_cnt_d   = fix_cnt_q;
    if (en && out_vld) begin
      sin_ch_d  = out_ch;
      sin_res_d = fix_val;
      for (int i = 0; i < NCH; i++) begin
        if (out_ch == CH_W'(i)) hold_d[32*i +: 32] = fix_val;
      end
      if (fix_hit && (fix_cnt_q != '1)) fix_cnt_d = fix_cnt_q + CNT_W'(1);
    end
  end

  // pipeline tag registers; reset flushes everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < CORE_LAT; i++) ch_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      ch_pipe_q  <= ch_pipe_d;
    end
  end

  // correction table with its power-up patch set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_vld_q <= '0;
      for (int i = 0; i < TBL_D; i++) begin
        tbl_match_q[i] <= '0;
        tbl_repl_q[i]  <= '0;
      end
      tbl_vld_q[0]   <= 1'b1;
      tbl_match_q[0] <= 32'h3f000000;
      tbl_repl_q[0]  <= 32'h3f800000;
      tbl_vld_q[1]   <= 1'b1;
      tbl_match_q[1] <= 32'hbf000000;
      tbl_repl_q[1]  <= 32'hbf800000;
      tbl_vld_q[2]   <= 1'b1;
      tbl_match_q[2] <= 32'hbf41bdce;
      tbl_repl_q[2]  <= 32'hba84ba1e;
    end else begin
      tbl_vld_q   <= tbl_vld_d;
      tbl_match_q <= tbl_match_d;
      tbl_repl_q  <= tbl_repl_d;
    end
  end

  // output-side state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sin_valid_q <= 1'b0;
      sin_ch_q    <= '0;
      sin_res_q   <= '0;
      hold_q      <= '0;
      fix_cnt_q   <= '0;
    end else begin
      sin_valid_q <= sin_valid_d;
      sin_ch_q    <= sin_ch_d;
      sin_res_q   <= sin_res_d;
      hold_q      <= hold_d;
      fix_cnt_q   <= fix_cnt_d;
    end
  end

  assign sin_valid = sin_valid_q;
  assign sin_ch    = sin_ch_q;
  assign sin_res   = sin_res_q;
  assign sin_hold  = hold_q;
  assign fix_cnt   = fix_cnt_q;

endmodule
